// File: rtl/arb2_mux_ctrl.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux onto one valid/ready channel.
// Per-grant burst limit hands the channel over while the other side is waiting.
module arb2_mux_ctrl #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    // One-hot grant encoding so each gnt output is a flop bit.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          last;
    logic          sel_q;

    assign gnt0      = state[0];
    assign gnt1      = state[1];
    assign sel       = sel_q;
    assign ack0      = gnt0 & req0 & out_ready;
    assign ack1      = gnt1 & req1 & out_ready;
    assign out_valid = (gnt0 & req0) | (gnt1 & req1);
    assign out_data  = sel_q ? data1 : data0;

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last ? G0 : G1;
                else if (req0)
                    state_nxt = G0;
                else if (req1)
                    state_nxt = G1;
            end
            G0: begin
                if (!req0)
                    state_nxt = req1 ? G1 : IDLE;
                else if (ack0) begin
                    if (cnt == LAST_BEAT) begin
                        cnt_nxt = '0;
                        if (req1)
                            state_nxt = G1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            G1: begin
                if (!req1)
                    state_nxt = req0 ? G0 : IDLE;
                else if (ack1) begin
                    if (cnt == LAST_BEAT) begin
                        cnt_nxt = '0;
                        if (req0)
                            state_nxt = G0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Every grant starts its burst budget from zero.
        if (state_nxt != state)
            cnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so all flops sample pre-edge values together.
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
            sel_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // sel moves on the same edge as gnt, and holds through IDLE.
            if (state_nxt == G0) begin
                last  <= 1'b0;
                sel_q <= 1'b0;
            end else if (state_nxt == G1) begin
                last  <= 1'b1;
                sel_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arb2_mux_ctrl.sv
// Directed bench for arb2_mux_ctrl (WIDTH=8, MAX_BURST=4) with hand-computed expectations.
// Flag vector order: {gnt1, gnt0, ack1, ack0, sel, out_valid}.
module tb_arb2_mux_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, out_ready;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, ack0, ack1, sel, out_valid;
    logic [7:0] out_data;
    logic [5:0] flags;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] F_IDLE0  = 6'b000000;
    localparam logic [5:0] F_IDLE1  = 6'b000010;
    localparam logic [5:0] F_G0_ACK = 6'b010101;
    localparam logic [5:0] F_G0_STL = 6'b010001;
    localparam logic [5:0] F_G0_REL = 6'b010000;
    localparam logic [5:0] F_G1_ACK = 6'b101011;
    localparam logic [5:0] F_G1_REL = 6'b100010;

    arb2_mux_ctrl #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign flags = {gnt1, gnt0, ack1, ack0, sel, out_valid};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past one rising edge; inputs are then driven well clear of the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
        data0 = 8'h3C; data1 = 8'hC3;
        tick();
        check("rst_flags", 32'(flags), 32'(F_IDLE0));
        check("rst_data", 32'(out_data), 32'h3C);
        tick();
        rst = 1'b0;

        // Single requester: one-edge grant latency, then an ack every cycle.
        req0 = 1'b1; data0 = 8'hA5; out_ready = 1'b1;
        #1;
        check("s1_pre_grant", 32'(flags), 32'(F_IDLE0));
        tick();
        check("s1_grant", 32'(flags), 32'(F_G0_ACK));
        check("s1_data", 32'(out_data), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s1_hold", 32'(flags), 32'(F_G0_ACK));
        end
        req0 = 1'b0;
        #1;
        check("s1_release", 32'(flags), 32'(F_G0_REL));
        tick();
        check("s1_idle", 32'(flags), 32'(F_IDLE0));

        // Both held from reset: 4 beats each side, alternating, never idle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        data0 = 8'h11; data1 = 8'h22;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            if (((k / 4) % 2) == 1) begin
                check("s2_g1", 32'(flags), 32'(F_G1_ACK));
                check("s2_d1", 32'(out_data), 32'h22);
            end else begin
                check("s2_g0", 32'(flags), 32'(F_G0_ACK));
                check("s2_d0", 32'(out_data), 32'h11);
            end
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("s2_idle", 32'(flags), 32'(F_IDLE0));

        // Lone requester 1: burst limit must not release the channel.
        req1 = 1'b1; data1 = 8'h5A;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("s3_g1", 32'(flags), 32'(F_G1_ACK));
            tick();
        end
        check("s3_still_g1", 32'(flags), 32'(F_G1_ACK));
        req1 = 1'b0;
        tick();
        check("s3_idle_sel", 32'(flags), 32'(F_IDLE1));
        check("s3_idle_data", 32'(out_data), 32'h5A);

        // Tie with last=1 grants G0; out_ready stalls freeze the beat count.
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h77; data1 = 8'h88;
        tick();
        check("s4_beat1", 32'(flags), 32'(F_G0_ACK));
        tick();
        check("s4_beat2", 32'(flags), 32'(F_G0_ACK));
        tick();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("s4_stall", 32'(flags), 32'(F_G0_STL));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("s4_beat3", 32'(flags), 32'(F_G0_ACK));
        tick();
        check("s4_beat4", 32'(flags), 32'(F_G0_ACK));
        tick();
        check("s4_handover", 32'(flags), 32'(F_G1_ACK));
        check("s4_data", 32'(out_data), 32'h88);

        // Owner releases after 2 beats; new grant restarts its count at 0.
        tick();
        check("s5_g1_beat2", 32'(flags), 32'(F_G1_ACK));
        tick();
        req1 = 1'b0;
        #1;
        check("s5_release", 32'(flags), 32'(F_G1_REL));
        tick();
        req1 = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("s5_g0_full", 32'(flags), 32'(F_G0_ACK));
            tick();
        end
        check("s5_back_g1", 32'(flags), 32'(F_G1_ACK));

        // Asynchronous reset mid-burst, then tie goes to requester 0.
        tick();
        #1;
        rst = 1'b1;
        #1;
        check("s6_async_rst", 32'(flags), 32'(F_IDLE0));
        tick();
        rst = 1'b0;
        #1;
        check("s6_idle", 32'(flags), 32'(F_IDLE0));
        tick();
        check("s6_tie_g0", 32'(flags), 32'(F_G0_ACK));
        check("s6_data", 32'(out_data), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arb2_mux_ctrl.md
# arb2_mux_ctrl

Two-requester round-robin arbiter that sequences a shared 2:1 mux datapath onto a single downstream valid/ready channel. It owns the mux select, grants one requester at a time, and enforces a per-grant burst limit so neither side can starve the other. It sits between two producer blocks and one consumer in the datapath layer, directly in front of the shared 2:1 mux.

## Interface
Parameters:
- WIDTH, 8, data width of each requester and of the output
- MAX_BURST, 4, maximum beats per grant while the other side is requesting; legal range ≥1

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 has a valid beat on data0
- data0  input  WIDTH  requester 0 data
- req1  input  1  requester 1 has a valid beat on data1
- data1  input  WIDTH  requester 1 data
- gnt0  output  1  requester 0 currently owns the channel (registered)
- gnt1  output  1  requester 1 currently owns the channel (registered)
- ack0  output  1  beat from requester 0 accepted this cycle (combinational)
- ack1  output  1  beat from requester 1 accepted this cycle (combinational)
- sel  output  1  mux select; 0 selects data0, 1 selects data1 (registered)
- out_data  output  WIDTH  sel ? data1 : data0 (combinational, ungated)
- out_valid  output  1  (gnt0 & req0) | (gnt1 & req1)
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready

## Operation
- States: IDLE, G0, G1. gnt0 = (state==G0), gnt1 = (state==G1). sel is 1 in G1, holds its last value in IDLE.
- last register: last granted requester. Reset value 1, so requester 0 wins the first tie.
- beat counter cnt, width clog2(MAX_BURST+1). It counts accepted beats in the current grant and clears on every state change.
- ackN = gntN & reqN & out_ready. A transfer occurs when ackN=1.
- IDLE:
  - only req0 → G0
  - only req1 → G1
  - both → grant the side opposite to last
  - neither → stay in IDLE
- GN, where O is the other side:
  - reqN=0 and reqO=1 → GO
  - reqN=0 and reqO=0 → IDLE
  - ackN=1 and cnt+1==MAX_BURST and reqO=1 → GO
  - ackN=1 and cnt+1==MAX_BURST and reqO=0 → stay in GN, cnt clears to 0
  - otherwise stay; cnt increments on ackN
- last updates to N on every entry into GN.
- Requesters must hold reqN and dataN stable until ackN. A requester dropping req without an ack is treated as release, not as an error.
- MAX_BURST=1 gives strict per-beat alternation while both request.

## Timing
- Reset (async assert, sync deassert assumed at system level) gives:
  - state=IDLE, gnt0=gnt1=0, sel=0, last=1, cnt=0
  - out_valid=0, ack0=ack1=0
  - out_data=data0
- Grant latency: a req rising in IDLE at edge N is granted, with gnt and sel updated, after edge N+1. The first possible ack is in the cycle following edge N+1.
- Handover GN→GO is direct, with no IDLE bubble. A requester whose req is held continuously sees gnt one cycle after the other side releases or hits its burst limit.
- After a handover, sel and gnt change on the same edge, so out_data never mixes sources with out_valid=1.
- out_ready low stalls the grant. cnt does not advance, and the burst limit counts accepted beats only, not cycles.
- A simultaneous release by the owner and a request from the other side switches on that edge.
- Reset asserted mid-burst returns the block to IDLE immediately. The in-flight beat is not acked.

## Test plan
- Reset, then req0=1, data0=8'hA5, out_ready=1 → after 1 edge gnt0=1, sel=0, out_data=A5, out_valid=1, ack0=1 every cycle; gnt1 stays 0.
- Both requests held from IDLE, out_ready=1, MAX_BURST=4 → G0 for 4 acks, then G1 for 4 acks, alternating indefinitely; no cycle with out_valid=0.
- Only req1 held for 10 beats with MAX_BURST=4 → stays in G1 throughout with 10 consecutive ack1; cnt wraps 0..3.
- In G0, req0 held but out_ready=0 for 5 cycles while req1=1 → no handover, cnt unchanged; handover happens after the 4th accepted beat once out_ready returns.
- Owner drops req after 2 beats with the other requesting → next edge grants the other, sel toggles, and cnt restarts at 0.
- rst asserted during G1 mid-burst → gnt1, out_valid and sel go to 0 asynchronously, state=IDLE; after release, a tie grants requester 0 first.
